// File: rtl/riscv_fetch_unit_if.sv
// rtl/riscv_fetch_unit_if.sv - instruction-memory request/response bus between fetch unit and memory
interface riscv_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            o_imem_req;
   logic [XLEN-1:0] o_imem_addr;
   logic            i_imem_gnt;
   logic            i_imem_rvalid;
   logic [31:0]     i_imem_rdata;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_gnt,
      input  i_imem_rvalid,
      input  i_imem_rdata
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_gnt,
      output i_imem_rvalid,
      output i_imem_rdata
   );
endinterface

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - pipelined fetch stage: PC, credit-limited imem requests, response FIFO, IF/ID register
module riscv_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall_f,
   input  logic            i_stall_d,
   input  logic            i_flush_d,
   input  logic            i_pc_src_e,
   input  logic [XLEN-1:0] i_pc_target_e,
   riscv_fetch_unit_if.master imem,
   output logic [31:0]     o_instr_d,
   output logic [XLEN-1:0] o_pc_d,
   output logic [XLEN-1:0] o_pc_plus4_d,
   output logic            o_valid_d
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

   logic [31:0]     fifo_instr_q [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
   logic [XLEN-1:0] tag_q        [FIFO_DEPTH];

   logic            ifid_valid_q, ifid_valid_d;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;

   logic            req, issue, dropping, push, pop, credit;
   logic [CW:0]     inflight;
   logic            unused_target_lsbs;

   assign unused_target_lsbs = ^i_pc_target_e[1:0];

   assign dropping = (drop_cnt_q != '0);
   assign push     = imem.i_imem_rvalid & ~dropping & ~i_pc_src_e;
   assign pop      = ~i_flush_d & ~i_stall_d & ~i_pc_src_e & (count_q != '0);

   // A slot freed by this cycle's pop may already be promised to a new request.
   assign inflight = {1'b0, outstanding_q} + {1'b0, count_q} - (CW+1)'(pop);
   assign credit   = (inflight < DEPTH_W);
   assign req      = ~i_rst & ~i_stall_f & ~i_pc_src_e & credit;
   assign issue    = req & imem.i_imem_gnt;

   assign imem.o_imem_req  = req;
   assign imem.o_imem_addr = fetch_pc_q;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q + CW'(issue) - CW'(imem.i_imem_rvalid);
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;

      if (i_pc_src_e) begin
         // Everything still on the bus belongs to the abandoned path.
         fetch_pc_d = {i_pc_target_e[XLEN-1:2], 2'b00};
         drop_cnt_d = outstanding_q - CW'(imem.i_imem_rvalid);
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
      end else begin
         if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            tag_wr_d   = tag_wr_q + 1'b1;
         end
         if (imem.i_imem_rvalid) begin
            if (dropping) begin
               drop_cnt_d = drop_cnt_q - 1'b1;
            end else begin
               tag_rd_d = tag_rd_q + 1'b1;
            end
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;

      if (i_flush_d) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP;
      end else if (i_stall_d) begin
         ifid_valid_d = ifid_valid_q;
      end else if (pop) begin
         ifid_valid_d = 1'b1;
         ifid_instr_d = fifo_instr_q[rd_ptr_q];
         ifid_pc_d    = fifo_pc_q[rd_ptr_q];
         ifid_pc4_d   = fifo_pc_q[rd_ptr_q] + XLEN'(4);
      end else begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         ifid_valid_q  <= 1'b0;
         ifid_instr_q  <= NOP;
         ifid_pc_q     <= '0;
         ifid_pc4_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
         ifid_valid_q  <= ifid_valid_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_pc4_q    <= ifid_pc4_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by the pointers above.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= imem.i_imem_rdata;
         fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
      end
      if (issue) begin
         tag_q[tag_wr_q] <= fetch_pc_q;
      end
   end

   assign o_instr_d    = ifid_instr_q;
   assign o_pc_d       = ifid_pc_q;
   assign o_pc_plus4_d = ifid_pc4_q;
   assign o_valid_d    = ifid_valid_q;

   a_no_overrun: assert property (@(posedge i_clk) disable iff (i_rst)
      !(push && !pop && count_q == CW'(FIFO_DEPTH)));
   a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
      !(imem.i_imem_rvalid && outstanding_q == '0));
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - self-checking bench for riscv_fetch_unit with bus model and scoreboard
module tb_riscv_fetch_unit;
   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_f, stall_d, flush_d, pc_src_e;
   logic [31:0] pc_target_e;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        valid_d;

   riscv_fetch_unit_if #(.XLEN(XLEN)) bus ();

   riscv_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_stall_f     (stall_f),
      .i_stall_d     (stall_d),
      .i_flush_d     (flush_d),
      .i_pc_src_e    (pc_src_e),
      .i_pc_target_e (pc_target_e),
      .imem          (bus.master),
      .o_instr_d     (instr_d),
      .o_pc_d        (pc_d),
      .o_pc_plus4_d  (pc_plus4_d),
      .o_valid_d     (valid_d)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { int lat; logic [31:0] target; logic [31:0] exp_addr; logic [31:0] exp_pc; } redir_vec_t;

   pend_t       pend_q[$];
   exp_t        exp_q[$];
   int          lat = 1;
   int          cyc = 0;
   logic [31:0] model_pc = 32'h0;
   logic        upd_prev = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0013_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // sel: 0 = o_valid_d, 1 = o_imem_req, 2 = i_imem_rvalid
   task automatic wait_for(input int sel, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if ((sel == 0 && valid_d) || (sel == 1 && bus.o_imem_req) || (sel == 2 && bus.i_imem_rvalid)) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout waiting for event %0d", name, sel);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Memory responder: in-order, fixed latency per request, no backpressure.
   initial begin
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.i_imem_rvalid = 1'b1;
            bus.i_imem_rdata  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
         end else begin
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_rdata  = 32'h0;
         end
      end
   end

   // Scoreboard: expected words queued at grant, compared when IF/ID loads a valid instruction.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         pend_q.delete();
         exp_q.delete();
         model_pc = 32'h0;
         upd_prev = 1'b0;
      end else begin
         if (upd_prev && valid_d) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_extra_instr: got valid pc %h, expected no instruction", pc_d);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_d, e.pc);
               check("sb_instr", instr_d, e.instr);
               check("sb_pc_plus4", pc_plus4_d, e.pc + 32'd4);
            end
         end
         upd_prev = !flush_d && !stall_d && !pc_src_e;
         if (pc_src_e) begin
            exp_q.delete();
            model_pc = {pc_target_e[31:2], 2'b00};
         end
         if (bus.o_imem_req && bus.i_imem_gnt) begin
            check("grant_addr", bus.o_imem_addr, model_pc);
            exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
            pend_q.push_back('{addr: bus.o_imem_addr, due: cyc + lat});
            model_pc = model_pc + 32'd4;
         end
      end
   end

   initial begin
      redir_vec_t  vecs[3];
      logic [31:0] held_instr, held_pc, held_addr;

      vecs[0] = '{lat: 2, target: 32'h0000_0103, exp_addr: 32'h0000_0100, exp_pc: 32'h0000_0100};
      vecs[1] = '{lat: 3, target: 32'h0000_2002, exp_addr: 32'h0000_2000, exp_pc: 32'h0000_2000};
      vecs[2] = '{lat: 2, target: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC};

      rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
      pc_target_e = 32'h0; bus.i_imem_gnt = 1'b1;

      @(negedge clk);
      check("rst_req", 32'(bus.o_imem_req), 32'h0);
      check("rst_valid", 32'(valid_d), 32'h0);
      check("rst_instr", instr_d, 32'h0000_0013);
      check("rst_pc", pc_d, 32'h0);
      check("rst_pc4", pc_plus4_d, 32'h0);
      step(1);
      rst = 1'b0;

      // Streaming from reset
      wait_for(2, "t1_first_rvalid");
      @(negedge clk);
      @(negedge clk);
      check("t1_first_valid", 32'(valid_d), 32'h1);
      check("t1_first_pc", pc_d, 32'h0);
      check("t1_first_instr", instr_d, mem_word(32'h0));
      step(8);

      // Decode stall: IF/ID holds, fetch runs out of credit
      stall_d = 1'b1;
      @(negedge clk);
      held_instr = instr_d;
      held_pc    = pc_d;
      repeat (4) begin
         @(negedge clk);
         check("t2_hold_instr", instr_d, held_instr);
         check("t2_hold_pc", pc_d, held_pc);
      end
      check("t2_req_no_credit", 32'(bus.o_imem_req), 32'h0);
      step(1);
      stall_d = 1'b0;
      step(8);

      // Redirects with wrong-path responses in flight
      for (int i = 0; i < 3; i++) begin
         stall_f = 1'b1;
         step(8);
         lat     = vecs[i].lat;
         stall_f = 1'b0;
         step(2);
         pc_src_e    = 1'b1;
         pc_target_e = vecs[i].target;
         @(negedge clk);
         check("t3_no_req_in_redirect", 32'(bus.o_imem_req), 32'h0);
         step(1);
         pc_src_e = 1'b0;
         wait_for(1, "t3_next_req");
         check("t3_next_addr", bus.o_imem_addr, vecs[i].exp_addr);
         wait_for(0, "t3_first_valid");
         check("t3_first_pc", pc_d, vecs[i].exp_pc);
         step(6);
      end
      lat = 1;
      step(8);

      // Flush and stall together: flush wins
      @(negedge clk);
      check("t4_pre_valid", 32'(valid_d), 32'h1);
      step(1);
      flush_d = 1'b1;
      stall_d = 1'b1;
      step(1);
      flush_d = 1'b0;
      stall_d = 1'b0;
      @(negedge clk);
      check("t4_valid", 32'(valid_d), 32'h0);
      check("t4_instr", instr_d, 32'h0000_0013);
      step(4);

      // Grant withheld: request stable, pipeline drains to bubbles
      bus.i_imem_gnt = 1'b0;
      @(negedge clk);
      held_addr = bus.o_imem_addr;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("t5_req_held", 32'(bus.o_imem_req), 32'h1);
         check("t5_addr_held", bus.o_imem_addr, held_addr);
         if (i == 3) check("t5_bubble", 32'(valid_d), 32'h0);
      end
      step(1);
      bus.i_imem_gnt = 1'b1;
      step(8);

      // Reset mid-stream
      rst = 1'b1;
      #1;
      check("t6_req", 32'(bus.o_imem_req), 32'h0);
      check("t6_valid", 32'(valid_d), 32'h0);
      check("t6_instr", instr_d, 32'h0000_0013);
      check("t6_pc", pc_d, 32'h0);
      check("t6_pc4", pc_plus4_d, 32'h0);
      step(2);
      rst = 1'b0;
      wait_for(1, "t6_restart_req");
      check("t6_restart_addr", bus.o_imem_addr, 32'h0);
      wait_for(0, "t6_restart_valid");
      check("t6_restart_pc", pc_d, 32'h0);
      step(6);

      stall_f = 1'b1;
      step(10);
      check("final_sb_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
